// File: rtl/pht_counter_table_pkg.sv
// Shared predictor definitions: counter width, counter constants, saturating
// arithmetic and the table controller state encoding.
package pht_counter_table_pkg;

    localparam int PHT_CNT_WIDTH = 2;

    localparam logic [PHT_CNT_WIDTH-1:0] CNT_MIN     = '0;
    localparam logic [PHT_CNT_WIDTH-1:0] CNT_MAX     = '1;
    localparam logic [PHT_CNT_WIDTH-1:0] CNT_ONE     = {{(PHT_CNT_WIDTH-1){1'b0}}, 1'b1};
    // Weakly-not-taken: just below the taken threshold (MSB clear, rest set).
    localparam logic [PHT_CNT_WIDTH-1:0] CNT_WEAK_NT = {1'b0, {(PHT_CNT_WIDTH-1){1'b1}}};

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } pht_state_e;

    function automatic logic [PHT_CNT_WIDTH-1:0] sat_inc(input logic [PHT_CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
    endfunction

    function automatic logic [PHT_CNT_WIDTH-1:0] sat_dec(input logic [PHT_CNT_WIDTH-1:0] cnt);
        return (cnt == CNT_MIN) ? cnt : cnt - CNT_ONE;
    endfunction

endpackage

// File: rtl/pht_counter_table_if.sv
// Query, prediction and training signals between the front end / EX stage
// (master) and the pattern history table (slave).
interface pht_counter_table_if
    import pht_counter_table_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int bh_width   = 14,
    parameter int cnt_width  = PHT_CNT_WIDTH
);

    logic                  stall;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [bh_width-1:0]   bh_q;
    logic                  pred_taken;
    logic [cnt_width-1:0]  pred_cnt;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] pc_update;
    logic [bh_width-1:0]   bh_ex;
    logic                  outcome_real;
    logic                  update_en;

    modport master (
        output stall, pc_q, bh_q, pc_update, bh_ex, outcome_real, update_en,
        input  pred_taken, pred_cnt, ready
    );

    modport slave (
        input  stall, pc_q, bh_q, pc_update, bh_ex, outcome_real, update_en,
        output pred_taken, pred_cnt, ready
    );

endinterface

// File: rtl/pht_counter_table_bram.sv
// Simple dual-port block RAM: one synchronous read port (read-first on
// address collision), one write port, no reset on the array.
module pht_counter_table_bram #(
    parameter int AW = 12,
    parameter int DW = 2
) (
    input  logic          clk_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] mem_q [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pht_idx_hash.sv
// Table index hash: low PC bits xor low history bits xor the folded-down
// upper history bits. Shared by the query and training paths.
module pht_idx_hash #(
    parameter int ADDR_WIDTH = 30,
    parameter int bh_width   = 14,
    parameter int pht_width  = 12
) (
    input  logic [ADDR_WIDTH-1:0] pc_i,
    input  logic [bh_width-1:0]   bh_i,
    output logic [pht_width-1:0]  idx_o
);

    localparam int HI_W = bh_width - pht_width;

    logic [pht_width-1:0] bh_hi;

    generate
        if (HI_W >= pht_width) begin : g_hi_wide
            assign bh_hi = bh_i[pht_width +: pht_width];
        end else begin : g_hi_narrow
            assign bh_hi = {{(pht_width-HI_W){1'b0}}, bh_i[bh_width-1:pht_width]};
        end
    endgenerate

    assign idx_o = pc_i[pht_width-1:0] ^ bh_i[pht_width-1:0] ^ bh_hi;

endmodule

// File: rtl/pht_counter_table.sv
// Pattern history table of 2-bit saturating counters: 1-cycle query,
// two-stage read-modify-write training, and a post-reset init sweep.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | sweep writes CNT_WEAK_NT to every entry; queries/updates dropped
//   ST_RUN  | serving queries and training until the next reset
module pht_counter_table
    import pht_counter_table_pkg::*;
#(
    parameter int ADDR_WIDTH = 30,
    parameter int bh_width   = 14,
    parameter int pht_width  = 12,
    parameter int cnt_width  = PHT_CNT_WIDTH
) (
    input logic                clk,
    input logic                rst,
    pht_counter_table_if.slave pht_bus
);

    localparam logic [pht_width-1:0] PTR_LAST = '1;
    localparam logic [pht_width-1:0] PTR_ONE  = {{(pht_width-1){1'b0}}, 1'b1};

    pht_state_e           state_q;
    logic [pht_width-1:0] ptr_q;
    logic                 ready_q;
    logic                 run;

    logic [pht_width-1:0] q_idx;
    logic [pht_width-1:0] u_idx;

    logic                 u1_valid_q;
    logic [pht_width-1:0] u1_idx_q;
    logic                 u1_outcome_q;
    logic                 u1_fwd_q;
    logic [cnt_width-1:0] u1_fwd_val_q;
    logic [cnt_width-1:0] u1_old;
    logic [cnt_width-1:0] u1_new_d;

    logic                 q_live_q;
    logic                 q_fwd_q;
    logic [cnt_width-1:0] q_fwd_val_q;
    logic [cnt_width-1:0] hold_q;
    logic [cnt_width-1:0] pred_cnt_d;

    logic                 wr_en;
    logic [pht_width-1:0] wr_addr;
    logic [cnt_width-1:0] wr_data;
    logic [cnt_width-1:0] rd_q_data;
    logic [cnt_width-1:0] rd_u_data;

    pht_idx_hash #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .bh_width  (bh_width),
        .pht_width (pht_width)
    ) u_hash_query (
        .pc_i (pht_bus.pc_q),
        .bh_i (pht_bus.bh_q),
        .idx_o(q_idx)
    );

    pht_idx_hash #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .bh_width  (bh_width),
        .pht_width (pht_width)
    ) u_hash_update (
        .pc_i (pht_bus.pc_update),
        .bh_i (pht_bus.bh_ex),
        .idx_o(u_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            ptr_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    ptr_q <= ptr_q + PTR_ONE;
                    if (ptr_q == PTR_LAST) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    state_q <= ST_RUN;
                end
                default: begin
                    state_q <= ST_INIT;
                    ptr_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign run = (state_q == ST_RUN);

    // A U0 read that collides with the U1 write in the same cycle sees stale
    // RAM data, so the fresh value is carried forward alongside it.
    assign u1_old   = u1_fwd_q ? u1_fwd_val_q : rd_u_data;
    assign u1_new_d = u1_outcome_q ? sat_inc(u1_old) : sat_dec(u1_old);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u1_valid_q   <= 1'b0;
            u1_idx_q     <= '0;
            u1_outcome_q <= 1'b0;
            u1_fwd_q     <= 1'b0;
            u1_fwd_val_q <= '0;
        end else begin
            u1_valid_q   <= run && pht_bus.update_en;
            u1_idx_q     <= u_idx;
            u1_outcome_q <= pht_bus.outcome_real;
            u1_fwd_q     <= u1_valid_q && (u1_idx_q == u_idx);
            u1_fwd_val_q <= u1_new_d;
        end
    end

    // Output is the RAM read data when the previous cycle captured a live
    // query, otherwise the held value (reset value while sweeping).
    assign pred_cnt_d = q_live_q ? (q_fwd_q ? q_fwd_val_q : rd_q_data) : hold_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_live_q    <= 1'b0;
            q_fwd_q     <= 1'b0;
            q_fwd_val_q <= '0;
            hold_q      <= '0;
        end else begin
            q_live_q    <= run && !pht_bus.stall;
            q_fwd_q     <= u1_valid_q && (u1_idx_q == q_idx);
            q_fwd_val_q <= u1_new_d;
            hold_q      <= pred_cnt_d;
        end
    end

    assign pht_bus.pred_cnt   = pred_cnt_d;
    assign pht_bus.pred_taken = pred_cnt_d[cnt_width-1];
    assign pht_bus.ready      = ready_q;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = ptr_q;
        wr_data = CNT_WEAK_NT;
        if (state_q == ST_INIT) begin
            wr_en = 1'b1;
        end else if (u1_valid_q) begin
            wr_en   = 1'b1;
            wr_addr = u1_idx_q;
            wr_data = u1_new_d;
        end
    end

    // Two replicas share the write port to give independent query and
    // training read ports.
    pht_counter_table_bram #(
        .AW(pht_width),
        .DW(cnt_width)
    ) u_bram_query (
        .clk_i  (clk),
        .re_i   (1'b1),
        .raddr_i(q_idx),
        .rdata_o(rd_q_data),
        .we_i   (wr_en),
        .waddr_i(wr_addr),
        .wdata_i(wr_data)
    );

    pht_counter_table_bram #(
        .AW(pht_width),
        .DW(cnt_width)
    ) u_bram_update (
        .clk_i  (clk),
        .re_i   (1'b1),
        .raddr_i(u_idx),
        .rdata_o(rd_u_data),
        .we_i   (wr_en),
        .waddr_i(wr_addr),
        .wdata_i(wr_data)
    );

endmodule

// File: tb/tb_pht_counter_table.sv
// Bench for pht_counter_table (16-entry table, 6-bit history): directed vector
// table plus random traffic checked against an array-based reference model.
module tb_pht_counter_table;

    localparam int AW    = 30;
    localparam int BHW   = 6;
    localparam int PW    = 4;
    localparam int CW    = 2;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pht_counter_table_if #(.ADDR_WIDTH(AW), .bh_width(BHW), .cnt_width(CW)) bus ();

    pht_counter_table #(
        .ADDR_WIDTH(AW),
        .bh_width  (BHW),
        .pht_width (PW),
        .cnt_width (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .pht_bus(bus)
    );

    typedef struct {
        logic [AW-1:0]  pc;
        logic [BHW-1:0] bh;
        logic           stall;
        logic           upd;
        logic [AW-1:0]  pcu;
        logic [BHW-1:0] bhu;
        logic           outc;
        int             exp_cnt;
    } vec_t;

    vec_t vecs[21];

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: counter array, cycles since reset release, the visible
    // prediction, and one training result waiting to be applied.
    int tbl[DEPTH];
    int m_n;
    int m_pred;
    bit pend_v;
    int pend_idx;
    bit pend_out;

    function automatic vec_t mk(input logic [AW-1:0] pc, input logic [BHW-1:0] bh,
                                input logic st, input logic upd, input logic [AW-1:0] pcu,
                                input logic [BHW-1:0] bhu, input logic outc, input int e);
        vec_t v;
        v.pc = pc; v.bh = bh; v.stall = st; v.upd = upd;
        v.pcu = pcu; v.bhu = bhu; v.outc = outc; v.exp_cnt = e;
        return v;
    endfunction

    function automatic int hidx(input logic [AW-1:0] pc, input logic [BHW-1:0] bh);
        int p, h;
        p = int'(pc % DEPTH);
        h = int'(bh);
        return (p ^ (h % DEPTH) ^ (h / DEPTH)) % DEPTH;
    endfunction

    function automatic int train(input int c, input bit up);
        if (up) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic drive(input logic [AW-1:0] pc, input logic [BHW-1:0] bh, input logic st,
                         input logic upd, input logic [AW-1:0] pcu, input logic [BHW-1:0] bhu,
                         input logic outc);
        bus.pc_q = pc; bus.bh_q = bh; bus.stall = st;
        bus.update_en = upd; bus.pc_update = pcu; bus.bh_ex = bhu; bus.outcome_real = outc;
    endtask

    task automatic idle();
        drive('0, '0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    // One clock: advance the model with the presented inputs, then check outputs.
    task automatic tick(input string tag);
        if (pend_v) tbl[pend_idx] = train(tbl[pend_idx], pend_out);
        pend_v = 1'b0;
        if (m_n >= DEPTH) begin
            if (!bus.stall) m_pred = tbl[hidx(bus.pc_q, bus.bh_q)];
            if (bus.update_en) begin
                pend_v   = 1'b1;
                pend_idx = hidx(bus.pc_update, bus.bh_ex);
                pend_out = bus.outcome_real;
            end
        end
        @(posedge clk);
        #1;
        if (m_n < DEPTH) m_n++;
        chk({tag, " pred_cnt"},   int'(bus.pred_cnt),   m_pred);
        chk({tag, " pred_taken"}, int'(bus.pred_taken), m_pred / 2);
        chk({tag, " ready"},      int'(bus.ready),      (m_n >= DEPTH) ? 1 : 0);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) tbl[i] = 1;
        m_n = 0; m_pred = 0; pend_v = 1'b0;
        chk({tag, " pred_cnt"},   int'(bus.pred_cnt),   0);
        chk({tag, " pred_taken"}, int'(bus.pred_taken), 0);
        chk({tag, " ready"},      int'(bus.ready),      0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(30'd3, 6'd0, 0, 1, 30'd5, 6'd0, 1, 1);
        vecs[1]  = mk(30'd5, 6'd0, 0, 1, 30'd5, 6'd0, 1, 2);
        vecs[2]  = mk(30'd5, 6'd0, 0, 1, 30'd5, 6'd0, 1, 3);
        vecs[3]  = mk(30'd5, 6'd0, 0, 1, 30'd3, 6'd0, 1, 3);
        vecs[4]  = mk(30'd3, 6'd0, 0, 1, 30'd3, 6'd0, 1, 2);
        vecs[5]  = mk(30'd3, 6'd0, 0, 1, 30'd3, 6'd0, 0, 3);
        vecs[6]  = mk(30'd3, 6'd0, 0, 1, 30'd3, 6'd0, 0, 2);
        vecs[7]  = mk(30'd3, 6'd0, 0, 1, 30'd3, 6'd0, 0, 1);
        vecs[8]  = mk(30'd3, 6'd0, 0, 1, 30'd3, 6'd0, 0, 0);
        vecs[9]  = mk(30'd3, 6'd0, 0, 1, 30'd3, 6'd0, 0, 0);
        vecs[10] = mk(30'd3, 6'd0, 0, 0, 30'd0, 6'd0, 0, 0);
        vecs[11] = mk(30'd0, 6'd0, 0, 1, 30'd7, 6'd0, 1, 1);
        vecs[12] = mk(30'd7, 6'd0, 0, 0, 30'd0, 6'd0, 0, 2);
        vecs[13] = mk(30'h1ABCDE05, 6'h31, 0, 0, 30'd0, 6'd0, 0, 2);
        vecs[14] = mk(30'd5, 6'd0, 0, 1, 30'd7, 6'h2C, 1, 3);
        vecs[15] = mk(30'd2, 6'd0, 1, 1, 30'd7, 6'h2C, 1, 3);
        vecs[16] = mk(30'd9, 6'd0, 1, 1, 30'd2, 6'd0, 0, 3);
        vecs[17] = mk(30'd0, 6'd0, 1, 0, 30'd0, 6'd0, 0, 3);
        vecs[18] = mk(30'd9, 6'd0, 0, 0, 30'd0, 6'd0, 0, 3);
        vecs[19] = mk(30'd2, 6'd0, 0, 0, 30'd0, 6'd0, 0, 0);
        vecs[20] = mk(30'd5, 6'd0, 0, 0, 30'd0, 6'd0, 0, 3);

        idle();
        #2;
        reset_pulse("por");
        repeat (DEPTH) tick("sweep");

        for (int i = 0; i < 21; i++) begin
            drive(vecs[i].pc, vecs[i].bh, vecs[i].stall, vecs[i].upd,
                  vecs[i].pcu, vecs[i].bhu, vecs[i].outc);
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d table", i), int'(bus.pred_cnt), vecs[i].exp_cnt);
        end

        idle();
        reset_pulse("run_rst");

        for (int i = 0; i < 9; i++) begin
            drive(AW'($urandom), BHW'($urandom), 1'b0, 1'b1, AW'(i), '0, 1'b1);
            tick("init_upd");
        end
        reset_pulse("sweep_rst");
        idle();
        repeat (DEPTH) tick("resweep");
        for (int i = 0; i < DEPTH; i++) begin
            drive(AW'(i), '0, 1'b0, 1'b0, '0, '0, 1'b0);
            tick("post_sweep");
            chk($sformatf("post_sweep entry%0d", i), int'(bus.pred_cnt), 1);
        end

        for (int i = 0; i < 400; i++) begin
            drive(AW'($urandom), BHW'($urandom), ($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 1)), AW'($urandom), BHW'($urandom),
                  ($urandom_range(0, 9) < 6));
            tick("rnd");
        end
        idle();
        repeat (3) tick("drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
